// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: RAM status plus the memory arbiter's state and grant-source encodings.
package cpu_types_pkg;

    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

    typedef enum logic [1:0] {ARB_IDLE, ARB_ISERVE, ARB_DSERVE} arbstate_t;

    typedef enum logic {SRC_I, SRC_D} arbsrc_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way combinational picker: the requester named by ptr wins if it is asking,
// otherwise the other one does.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       win,
    output logic       vld
);

    assign vld = |req;
    assign win = req[ptr] ? ptr : ~ptr;

endmodule

// File: rtl/mem_arbiter.sv
// Two-CPU arbiter for the shared RAM port; dcache beats are locked as one two-word grant.
// Define ARB_ROUND_ROBIN_EN to rotate CPU priority; otherwise CPU0 always wins ties.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int LOCK_HOLD = 2,
    parameter int CPUS      = 2
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [CPUS-1:0]           iREN,
    input  logic [CPUS-1:0][31:0]     iaddr,
    input  logic [CPUS-1:0]           dREN,
    input  logic [CPUS-1:0]           dWEN,
    input  logic [CPUS-1:0][31:0]     daddr,
    input  logic [CPUS-1:0][31:0]     dstore,
    output logic [CPUS-1:0]           iwait,
    output logic [CPUS-1:0]           dwait,
    output logic [CPUS-1:0][31:0]     iload,
    output logic [CPUS-1:0][31:0]     dload,
    output logic                      ramREN,
    output logic                      ramWEN,
    output logic [31:0]               ramaddr,
    output logic [31:0]               ramstore,
    input  logic [31:0]               ramload,
    input  ramstate_t                 ramstate
);

    localparam int HW = $clog2(LOCK_HOLD + 1);

    arbstate_t       state, state_nx;
    arbsrc_t         gsrc, gsrc_nx;
    logic            gcpu, gcpu_nx;
    logic            beat, beat_nx;
    logic [HW-1:0]   holdcnt, holdcnt_nx;
    logic            rr;
    logic [1:0]      dreq;
    logic            d_win, d_vld, i_win, i_vld;
    logic            g_req, g_acc, hold_last;

    assign dreq = dREN | dWEN;

    rr_pick2 u_dpick (.req(dreq), .ptr(rr), .win(d_win), .vld(d_vld));
    rr_pick2 u_ipick (.req(iREN), .ptr(rr), .win(i_win), .vld(i_vld));

    // Live request of whoever currently holds the grant
    assign g_req     = (gsrc == SRC_D) ? dreq[gcpu] : iREN[gcpu];
    assign g_acc     = g_req && (ramstate == ACCESS);
    assign hold_last = (int'(holdcnt) + 1 >= LOCK_HOLD);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= ARB_IDLE;
            gsrc    <= SRC_D;
            gcpu    <= 1'b0;
            beat    <= 1'b0;
            holdcnt <= '0;
        end else begin
            state   <= state_nx;
            gsrc    <= gsrc_nx;
            gcpu    <= gcpu_nx;
            beat    <= beat_nx;
            holdcnt <= holdcnt_nx;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Priority flips only when a grant finishes normally, not when it is abandoned
    logic fin;
    assign fin = ((state == ARB_ISERVE) && g_acc) ||
                 ((state == ARB_DSERVE) && beat && (g_acc || (!g_req && hold_last)));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)      rr <= 1'b0;
        else if (fin) rr <= ~rr;
    end
`else
    assign rr = 1'b0;
`endif

    always_comb begin
        state_nx   = state;
        gsrc_nx    = gsrc;
        gcpu_nx    = gcpu;
        beat_nx    = beat;
        holdcnt_nx = holdcnt;
        case (state)
            ARB_IDLE: begin
                if (d_vld) begin
                    state_nx = ARB_DSERVE;
                    gsrc_nx  = SRC_D;
                    gcpu_nx  = d_win;
                    beat_nx  = 1'b0;
                end else if (i_vld) begin
                    state_nx = ARB_ISERVE;
                    gsrc_nx  = SRC_I;
                    gcpu_nx  = i_win;
                end
            end
            ARB_ISERVE: begin
                if (g_acc || !g_req) state_nx = ARB_IDLE;
            end
            ARB_DSERVE: begin
                if (!beat) begin
                    if (g_acc) begin
                        beat_nx    = 1'b1;
                        holdcnt_nx = '0;
                    end else if (!g_req) begin
                        state_nx = ARB_IDLE;
                    end
                end else if (g_acc) begin
                    state_nx = ARB_IDLE;
                end else if (!g_req) begin
                    // Lock window between beats; give the RAM back once it runs out
                    if (hold_last) state_nx = ARB_IDLE;
                    else           holdcnt_nx = holdcnt + 1'b1;
                end
            end
            default: state_nx = ARB_IDLE;
        endcase
    end

    always_comb begin
        iwait    = '1;
        dwait    = '1;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state)
            ARB_ISERVE: begin
                ramREN      = iREN[gcpu];
                ramaddr     = iaddr[gcpu];
                iwait[gcpu] = ~g_acc;
            end
            ARB_DSERVE: begin
                ramWEN      = dWEN[gcpu];
                ramREN      = dREN[gcpu] & ~dWEN[gcpu];
                ramaddr     = daddr[gcpu];
                ramstore    = dstore[gcpu];
                dwait[gcpu] = ~g_acc;
            end
            default: ;
        endcase
    end

    assign iload = {CPUS{ramload}};
    assign dload = {CPUS{ramload}};

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-CPU memory arbiter that sits between the per-CPU icache/dcache request ports and the single shared RAM port. It grants the RAM to one of four requesters (dcache0, dcache1, icache0, icache1) and forwards that requester's read/write to the RAM. Each dcache two-word block transfer is held as one locked grant, so the two words cannot be split by another requester. All other requesters see `wait` asserted until they are served.

## Interface
Parameters:
- LOCK_HOLD, default 2: idle cycles the dcache lock is held between beat 0 and beat 1 while the dcache's REN/WEN is deasserted.
- CPUS, default 2: number of CPUs; fixed at 2 in this block.

Ports (all `[1:0]` arrays are indexed by CPUID):
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- iREN  in  [1:0]  icache read request.
- iaddr  in  [1:0][31:0]  icache word address.
- dREN  in  [1:0]  dcache read request.
- dWEN  in  [1:0]  dcache write request.
- daddr  in  [1:0][31:0]  dcache word address.
- dstore  in  [1:0][31:0]  dcache write data.
- iwait  out  [1:0]  low for exactly the cycle an icache read completes.
- dwait  out  [1:0]  low for exactly the cycle a dcache access completes.
- iload  out  [1:0][31:0]  RAM read data, broadcast to every icache.
- dload  out  [1:0][31:0]  RAM read data, broadcast to every dcache.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  ramstate_t  RAM status: FREE, BUSY, ACCESS or ERROR.

## Operation
- FSM has three states: IDLE, ISERVE, DSERVE.
- Registered grant: `gsrc` holds the source type (I or D), `gcpu` holds the CPU index.
- Additional registers:
  - `beat`: 0 or 1.
  - `holdcnt`: width $clog2(LOCK_HOLD+1).
  - `rr`: round-robin pointer, 1 bit.
- Arbitration in IDLE:
  - Any dcache request (dREN|dWEN) beats any icache request.
  - Within the same type, the CPU equal to `rr` wins if it is requesting; otherwise the other CPU wins.
  - With no request the FSM stays in IDLE.
  - A winning dcache request loads `beat=0` and moves to DSERVE. A winning icache request moves to ISERVE.
- While in ISERVE or DSERVE:
  - ramREN, ramWEN, ramaddr and ramstore are driven from the granted source, combinationally from its live inputs.
  - A dREN/dWEN pair with both bits set counts as a write.
- Completion: ramstate==ACCESS while the granted source is requesting makes that source's wait output 0 in the same cycle.
- ISERVE:
  - ACCESS → IDLE, `rr` toggles.
  - Granted iREN dropped before ACCESS → IDLE, `rr` unchanged.
- DSERVE:
  - ACCESS with beat=0 → beat=1, holdcnt=0. Remain in DSERVE.
  - ACCESS with beat=1 → IDLE, `rr` toggles.
  - beat=1 with the granted dcache not requesting: holdcnt increments each cycle. When holdcnt reaches LOCK_HOLD → IDLE, `rr` toggles.
  - beat=0 with the request dropped before ACCESS → IDLE, `rr` unchanged.
- Ungranted requesters and idle ports: waits held at 1, RAM enables 0, ramaddr/ramstore 0.
- iload and dload always equal ramload.
- ERROR and BUSY are both treated as not-ready: wait stays high and the FSM does not advance.

## Timing
- Reset values:
  - FSM in IDLE; beat=0, holdcnt=0, rr=0, gsrc=D, gcpu=0.
  - iwait=2'b11, dwait=2'b11.
  - ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
- Reset asserted mid-transfer: the FSM returns to IDLE immediately (asynchronously) and the RAM enables drop in the same cycle.
- Latency for a request first seen in cycle N while in IDLE:
  - The RAM is driven from cycle N+1.
  - The earliest wait-low is cycle N+1, if ramstate==ACCESS in that cycle.
  - The arbiter adds no latency beyond that.
- Cycle after a grant completes: the FSM is in IDLE. The next grant is made in that cycle and drives the RAM one cycle later, so there is a one-cycle gap between grants.
- Simultaneous requests:
  - Requests from all four sources: dcache[rr] wins.
  - Requests from both icaches only: icache[rr] wins.
- dcache lock: beat 1 may arrive up to LOCK_HOLD cycles after beat 0. During that window every other requester is blocked.

## Configuration
- ARB_ROUND_ROBIN_EN defined: behaviour as above; `rr` toggles after each completed grant.
- ARB_ROUND_ROBIN_EN undefined:
  - `rr` is tied to 0 and its register is removed.
  - CPU0 has fixed priority within each type.
  - The dcache-over-icache priority is unchanged.

## Structure
- Add to cpu_types_pkg:
  - `typedef enum logic [1:0] {ARB_IDLE, ARB_ISERVE, ARB_DSERVE} arbstate_t`
  - `typedef enum logic {SRC_I, SRC_D} arbsrc_t`
- ramstate_t already exists in cpu_types_pkg and is reused.
- One sub-module, `rr_pick2`:
  - Inputs: 2-bit request vector, priority pointer.
  - Outputs: winner index, valid.
  - Purely combinational; instantiated twice, once for the dcache requests and once for the icache requests.

## Test plan
- Reset, then request dREN[0] with daddr[0]=0x40 and ramstate=ACCESS:
  - ramREN=1 and ramaddr=0x40 one cycle after the request.
  - dwait[0]=0 for exactly one cycle.
- Both dcaches and both icaches request in the same cycle with rr=0:
  - Service order is d0 (both beats) → d1 (both beats) → i0 → i1.
  - No interleaving inside a d-block.
- d0 beat 0 completes, then dREN[0] drops for 1 cycle while iREN[1] requests:
  - i1 is not granted.
  - d0 beat 1 at daddr=0x44 completes before i1 is granted.
- d0 beat 0 completes, then no request from d0 for LOCK_HOLD=2 cycles:
  - The FSM returns to IDLE.
  - A pending iREN[0] is granted in the next cycle.
- ramstate=BUSY for 3 cycles, then ACCESS, with a write dWEN[1] of 0xDEADBEEF:
  - ramWEN=1 with ramstore=0xDEADBEEF held for all 4 cycles.
  - dwait[1] low only in the ACCESS cycle.
- RST is pulsed mid-DSERVE:
  - All waits go to 1 and ramREN/ramWEN go to 0 asynchronously.
  - After release the FSM is in IDLE with rr=0.
